// File: rtl/core_pkg.sv
// Shared core definitions: RV64 major opcodes, fetch FSM states and the default reset PC.
package core_pkg;

  localparam logic [63:0] DefaultResetPc = 64'h0;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpLui     = 7'b0110111;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OpLoad, OpOpImm, OpJalr, OpOpImm32, OpStore, OpOp,
      OpOp32, OpBranch, OpJal, OpAuipc, OpLui: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO for fetched entries; flush empties it, push and pop may coincide.
module fetch_buffer #(
  parameter int unsigned Width = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // Empty buffer presents zeros so the decoder-facing fields are clean after reset/flush.
  assign head_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding memory read, 2-entry decode buffer, redirect flush.
// Define FETCH_ILLEGAL_CHECK_EN to flag unsupported major opcodes per buffered entry.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DefaultResetPc
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [63:0] o_mem_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [63:0] o_instr_pc,
  output logic        o_instr_illegal
);

`ifdef FETCH_ILLEGAL_CHECK_EN
  localparam int unsigned EntryWidth = 97;
`else
  localparam int unsigned EntryWidth = 96;
`endif

  fetch_state_e          state_q, state_d;
  logic [63:0]           pc_q, pc_d;
  logic [63:0]           req_pc_q, req_pc_d;
  logic                  req_fire;
  logic                  buf_push;
  logic                  buf_pop;
  logic [1:0]            buf_count;
  logic [EntryWidth-1:0] push_entry;
  logic [EntryWidth-1:0] head_entry;

  // In REQ nothing is outstanding, so the reservation reduces to a free buffer slot.
  assign o_mem_req_valid = (state_q == StReq) && (buf_count != 2'd2);
  assign o_mem_addr      = pc_q;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  assign buf_push = (state_q == StWait) && i_mem_rsp_valid && !i_redirect;
  assign buf_pop  = o_instr_valid && i_instr_ready && !i_redirect;

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign push_entry      = {req_pc_q, i_mem_rsp_data, ~opcode_supported(i_mem_rsp_data[6:0])};
  assign o_instr_illegal = head_entry[0];
`else
  assign push_entry      = {req_pc_q, i_mem_rsp_data};
  assign o_instr_illegal = 1'b0;
`endif

  assign o_instr_pc    = head_entry[EntryWidth-1 -: 64];
  assign o_instr       = head_entry[EntryWidth-65 -: 32];
  assign o_instr_valid = (buf_count != 2'd0);

  fetch_buffer #(
    .Width(EntryWidth)
  ) u_buffer (
    .clk      (i_clk),
    .rst      (i_rst),
    .flush    (i_redirect),
    .push     (buf_push),
    .push_data(push_entry),
    .pop      (buf_pop),
    .head_data(head_entry),
    .count    (buf_count)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;

    if (req_fire) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 64'd4;
    end

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        // A request issued alongside a redirect is still in flight and must be discarded.
        if (req_fire) state_d = i_redirect ? StDrop : StWait;
      end
      StWait: begin
        if (i_mem_rsp_valid) state_d = StReq;
        else if (i_redirect) state_d = StDrop;
      end
      StDrop: begin
        if (i_mem_rsp_valid) state_d = StReq;
      end
    endcase

    if (i_redirect) pc_d = i_redirect_pc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: a behavioural memory responder plus a
// program-order model of what the decoder must see after reset and each redirect.
module tb_fetch_unit;

  localparam logic [63:0] ResetPc = 64'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_illegal;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(ResetPc)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_req_ready),
    .o_mem_addr     (mem_addr),
    .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rsp_data (mem_rsp_data),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_instr_valid  (instr_valid),
    .i_instr_ready  (instr_ready),
    .o_instr        (instr),
    .o_instr_pc     (instr_pc),
    .o_instr_illegal(instr_illegal)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural program memory: word content is a hash of the address.
  function automatic logic [6:0] pick_op(input logic [3:0] k);
    case (k)
      4'd0:    return 7'b0000011;
      4'd1:    return 7'b0010011;
      4'd2:    return 7'b1100111;
      4'd3:    return 7'b0011011;
      4'd4:    return 7'b0100011;
      4'd5:    return 7'b0110011;
      4'd6:    return 7'b0111011;
      4'd7:    return 7'b1100011;
      4'd8:    return 7'b1101111;
      4'd9:    return 7'b0010111;
      4'd10:   return 7'b0110111;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'h3000) return 32'h0000_007F;
    if (a == 64'h3004) return 32'h0000_0013;
    h = (a[31:0] ^ a[63:32]) * 32'h9E37_79B1;
    return {h[31:7], pick_op(h[11:8])};
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHECK_EN
    return !(w[6:0] inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011,
                            7'b0110011, 7'b0111011, 7'b1100011, 7'b1101111, 7'b0010111,
                            7'b0110111});
`else
    return (w[6:0] == 7'h80);
`endif
  endfunction

  // Model state
  logic [63:0] fetch_pc;
  logic [63:0] exp_pc;
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_req_addr;
  int          consumed;

  bit          prev_hold;
  bit          prev_redir;
  logic [31:0] prev_instr;
  logic [63:0] prev_ipc;
  logic        prev_ill;

  // Stimulus knobs
  int unsigned mem_pct;
  int unsigned dec_pct;
  int unsigned redir_pct;
  int unsigned lat_min;
  int unsigned lat_max;
  bit          force_redir;
  logic [63:0] force_pc;

  logic [63:0] hs_log[$];
  logic [63:0] pc_log[$];
  logic        ill_log[$];

  function automatic logic [63:0] hs_at(input int i);
    return (i < hs_log.size()) ? hs_log[i] : 64'hx;
  endfunction

  function automatic logic [63:0] pc_at(input int i);
    return (i < pc_log.size()) ? pc_log[i] : 64'hx;
  endfunction

  function automatic logic ill_at(input int i);
    return (i < ill_log.size()) ? ill_log[i] : 1'bx;
  endfunction

  task automatic clear_logs();
    hs_log.delete();
    pc_log.delete();
    ill_log.delete();
  endtask

  task automatic do_reset(input int n);
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 64'h0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_req_ready = 1'b0;
    instr_ready   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_mem_addr", mem_addr, ResetPc);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 64'h0);
    check_eq("rst_illegal", instr_illegal, 1'b0);
    rst        = 1'b0;
    mem_busy   = 1'b0;
    fetch_pc   = ResetPc;
    exp_pc     = ResetPc;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
  endtask

  // One cycle: drive inputs, check observed outputs against the model, advance the model.
  task automatic tick();
    bit rsp_now;
    bit hs;
    bit take;
    rsp_now = 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) rsp_now = 1'b1;
      else mem_cnt--;
    end
    mem_rsp_valid = rsp_now;
    mem_rsp_data  = rsp_now ? mem_word(mem_req_addr) : 32'h0;
    mem_req_ready = ($urandom_range(99) < mem_pct);
    instr_ready   = ($urandom_range(99) < dec_pct);
    redirect      = force_redir || ($urandom_range(99) < redir_pct);
    redirect_pc   = force_redir ? force_pc : ({$urandom, $urandom} & ~64'h3);

    if (prev_redir) check_eq("valid_after_redirect", instr_valid, 1'b0);
    if (prev_hold) begin
      check_eq("hold_valid", instr_valid, 1'b1);
      check_eq("hold_instr", instr, prev_instr);
      check_eq("hold_pc", instr_pc, prev_ipc);
      check_eq("hold_illegal", instr_illegal, prev_ill);
    end
    if (mem_req_valid) begin
      check_eq("one_outstanding", mem_busy, 1'b0);
      check_eq("mem_addr", mem_addr, fetch_pc);
    end

    take = instr_valid && instr_ready && !redirect;
    if (take) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instr_word", instr, mem_word(exp_pc));
      check_eq("instr_illegal", instr_illegal, exp_illegal(mem_word(exp_pc)));
      pc_log.push_back(instr_pc);
      ill_log.push_back(instr_illegal);
      exp_pc = exp_pc + 64'd4;
      consumed++;
    end

    hs = mem_req_valid && mem_req_ready;
    if (rsp_now) mem_busy = 1'b0;
    if (hs) begin
      mem_busy     = 1'b1;
      mem_cnt      = $urandom_range(lat_max, lat_min);
      mem_req_addr = mem_addr;
      hs_log.push_back(mem_addr);
      fetch_pc = fetch_pc + 64'd4;
    end
    if (redirect) begin
      fetch_pc = redirect_pc;
      exp_pc   = redirect_pc;
    end
    prev_hold  = instr_valid && !instr_ready && !redirect;
    prev_instr = instr;
    prev_ipc   = instr_pc;
    prev_ill   = instr_illegal;
    prev_redir = redirect;
    @(posedge clk);
    #1;
  endtask

  task automatic set_knobs(input int unsigned mp, input int unsigned dp, input int unsigned rp,
                           input int unsigned lmin, input int unsigned lmax);
    mem_pct   = mp;
    dec_pct   = dp;
    redir_pct = rp;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  task automatic redirect_to(input logic [63:0] target);
    force_redir = 1'b1;
    force_pc    = target;
    tick();
    force_redir = 1'b0;
    clear_logs();
  endtask

  initial begin
    bit   found;
    logic exp_ill_7f;
    int   base;
`ifdef FETCH_ILLEGAL_CHECK_EN
    exp_ill_7f = 1'b1;
`else
    exp_ill_7f = 1'b0;
`endif
    force_redir = 1'b0;
    force_pc    = 64'h0;
    consumed    = 0;
    mem_cnt     = 0;

    // Straight-line fetch from reset
    do_reset(3);
    set_knobs(100, 100, 0, 1, 1);
    clear_logs();
    repeat (14) tick();
    check_eq("seq_hs0", hs_at(0), 64'h1000);
    check_eq("seq_hs1", hs_at(1), 64'h1004);
    check_eq("seq_hs2", hs_at(2), 64'h1008);
    check_eq("seq_pc0", pc_at(0), 64'h1000);
    check_eq("seq_pc1", pc_at(1), 64'h1004);
    check_eq("seq_pc2", pc_at(2), 64'h1008);

    // Decoder stall fills exactly two entries, then drains in order
    do_reset(2);
    set_knobs(100, 0, 0, 1, 1);
    clear_logs();
    repeat (20) tick();
    check_eq("stall_req_valid", mem_req_valid, 1'b0);
    check_eq("stall_instr_valid", instr_valid, 1'b1);
    check_eq("stall_head_pc", instr_pc, 64'h1000);
    check_eq("stall_hs_count", hs_log.size(), 2);
    set_knobs(0, 100, 0, 1, 1);
    repeat (5) tick();
    check_eq("drain_count", pc_log.size(), 2);
    check_eq("drain_pc0", pc_at(0), 64'h1000);
    check_eq("drain_pc1", pc_at(1), 64'h1004);
    check_eq("drain_empty", instr_valid, 1'b0);
    set_knobs(100, 100, 0, 1, 1);
    clear_logs();
    repeat (4) tick();
    check_eq("resume_hs", hs_at(0), 64'h1008);

    // Redirect in WAIT; the response arrives three cycles after the handshake
    set_knobs(100, 100, 0, 3, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy && mem_cnt == 3) found = 1'b1;
      else tick();
    end
    check_eq("wait_found", found, 1'b1);
    redirect_to(64'h2000);
    set_knobs(100, 100, 0, 1, 1);
    repeat (12) tick();
    check_eq("wait_redir_hs", hs_at(0), 64'h2000);
    check_eq("wait_redir_pc", pc_at(0), 64'h2000);

    // Redirect on the same cycle as the response
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy && mem_cnt == 1) found = 1'b1;
      else tick();
    end
    check_eq("rsp_found", found, 1'b1);
    redirect_to(64'h2400);
    check_eq("rsp_redir_no_valid", instr_valid, 1'b0);
    repeat (12) tick();
    check_eq("rsp_redir_hs", hs_at(0), 64'h2400);
    check_eq("rsp_redir_pc", pc_at(0), 64'h2400);

    // Address wrap at the top of the 64-bit space
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    repeat (14) tick();
    check_eq("wrap_hs0", hs_at(0), 64'hFFFF_FFFF_FFFF_FFF8);
    check_eq("wrap_hs1", hs_at(1), 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_hs2", hs_at(2), 64'h0);
    check_eq("wrap_pc2", pc_at(2), 64'h0);

    // Illegal-opcode flag on known words
    redirect_to(64'h3000);
    repeat (10) tick();
    check_eq("ill_pc0", pc_at(0), 64'h3000);
    check_eq("ill_7f", ill_at(0), exp_ill_7f);
    check_eq("ill_13", ill_at(1), 1'b0);

    // Randomized traffic with redirects and one mid-run reset
    set_knobs(75, 70, 3, 1, 4);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      tick();
    end
    set_knobs(100, 100, 0, 1, 2);
    base = consumed;
    repeat (60) tick();
    check_eq("progress", (consumed - base) > 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
